// File: rtl/fifo_wptr_ctrl_pkg.sv
// Shared definitions for the async FIFO pointer controllers (write and read side).
// The Gray helpers work at the widest legal pointer width. Callers zero-extend
// their operand and truncate the result back to their own width.
package fifo_wptr_ctrl_pkg;

  // Widest pointer: ABITS max 16, plus the wrap bit.
  localparam int MAX_W = 17;

  // Binary to Gray. A zero-extended input produces a zero-extended result.
  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary as an MSB-down prefix XOR. Leading zeros pass through unchanged.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary converter for a synchronized pointer.
module fifo_gray2bin
  import fifo_wptr_ctrl_pkg::*;
#(
  parameter int WIDTH = 11
) (
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_bin
);

  // Pure conversion with no state. The input is already in the local clock domain.
  assign o_bin = WIDTH'(gray2bin(MAX_W'(i_gray)));

endmodule

// File: rtl/fifo_wptr_ctrl.sv
// Write-side pointer controller for an asynchronous FIFO.
// It owns the binary and Gray write pointers and the full, almost-full, level
// and sticky overflow flags. Every flag is computed from the next-state pointer,
// so it is valid in the same cycle the pointer moves. The read pointer arrives
// already synchronized. This block holds no CDC flops.
// Handshake: a write happens in any cycle where wr_allow (wr_en & ~wr_full) is
// high. A wr_en that arrives while the FIFO is full is dropped and recorded in
// wr_overflow.
module fifo_wptr_ctrl
  import fifo_wptr_ctrl_pkg::*;
#(
  parameter int ABITS    = 10,
  parameter int AFULL_TH = (1 << ABITS) - 4
) (
  input  logic             wrclk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [ABITS:0]   rd_gray_sync,
  input  logic             ovf_clr,
  output logic             wr_allow,
  output logic [ABITS-1:0] wr_bin_ptr,
  output logic [ABITS:0]   wr_gray_ptr,
  output logic             wr_full,
  output logic             wr_afull,
  output logic [ABITS:0]   wr_level,
  output logic             wr_overflow
);

  logic [ABITS:0] r_wbin;
  logic [ABITS:0] r_wgray;
  logic           r_full;
  logic           r_afull;
  logic [ABITS:0] r_level;
  logic           r_ovf;

  logic [ABITS:0] w_wbin_next;
  logic [ABITS:0] w_wgray_next;
  logic [ABITS:0] w_rd_bin;
  logic [ABITS:0] w_level_next;
  logic           w_full_next;
  logic           w_afull_next;
  logic           w_ovf_next;

  fifo_gray2bin #(
    .WIDTH(ABITS + 1)
  ) u_rd_g2b (
    .i_gray(rd_gray_sync),
    .o_bin (w_rd_bin)
  );

  // Write acceptance depends only on the registered full flag. Reset does not gate it.
  assign wr_allow = wr_en & ~r_full;

  // Next-state pointer and the flags derived from it.
  always_comb begin
    w_wbin_next  = r_wbin + (ABITS+1)'(wr_allow);
    w_wgray_next = (ABITS+1)'(bin2gray(MAX_W'(w_wbin_next)));
    // Full: the Gray pointers differ only in their two MSBs, meaning exactly one lap apart.
    w_full_next  = (w_wgray_next == {~rd_gray_sync[ABITS:ABITS-1], rd_gray_sync[ABITS-2:0]});
    w_level_next = w_wbin_next - w_rd_bin;
    // Widen by one bit so a threshold of 2^ABITS compares correctly.
    w_afull_next = ({1'b0, w_level_next} >= (ABITS+2)'(AFULL_TH));
    // If a set and a clear land in the same cycle, the set wins.
    w_ovf_next   = (wr_en & r_full) | (r_ovf & ~ovf_clr);
  end

  // Pointer and flag registers with synchronous reset.
  always_ff @(posedge wrclk) begin
    if (rst) begin
      r_wbin  <= '0;
      r_wgray <= '0;
      r_full  <= 1'b0;
      r_afull <= 1'b0;
      r_level <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_wbin  <= w_wbin_next;
      r_wgray <= w_wgray_next;
      r_full  <= w_full_next;
      r_afull <= w_afull_next;
      r_level <= w_level_next;
      r_ovf   <= w_ovf_next;
    end
  end

  assign wr_bin_ptr  = r_wbin[ABITS-1:0];
  assign wr_gray_ptr = r_wgray;
  assign wr_full     = r_full;
  assign wr_afull    = r_afull;
  assign wr_level    = r_level;
  assign wr_overflow = r_ovf;

endmodule
